// File: rtl/divider_pkg.sv
// rtl/divider_pkg.sv - shared states and constants for the 128/64 restoring divider
package divider_pkg;

  localparam int WIDTH_DEF = 64;

  // Quotient reported for divide-by-zero and quotient overflow; sliced to WIDTH at use.
  localparam logic [127:0] ERR_QUOTIENT = '1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CHECK = 2'd1,
    S_DIV   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/divider_step.sv
// rtl/divider_step.sv - one combinational restoring division step
module divider_step #(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic             bit_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_out,
  output logic             qbit
);

  logic [WIDTH:0] w_shift;
  logic [WIDTH:0] w_trial;

  // rem_in < divisor keeps w_shift < 2*divisor, so trial's top bit is exactly the borrow.
  assign w_shift = {rem_in, bit_in};
  assign w_trial = w_shift - {1'b0, divisor};
  assign qbit    = ~w_trial[WIDTH];
  assign rem_out = qbit ? w_trial[WIDTH-1:0] : w_shift[WIDTH-1:0];

endmodule

// File: rtl/divider_128_by_64.sv
// rtl/divider_128_by_64.sv - iterative unsigned 2W/W divider; DIVIDER_128_BY_64_RADIX4_EN selects 2 bits/cycle
module divider_128_by_64
  import divider_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = 7
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2*WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0]   divisor,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   quotient,
  output logic [WIDTH-1:0]   remainder,
  output logic               div_zero,
  output logic               overflow
);

`ifdef DIVIDER_128_BY_64_RADIX4_EN
  localparam int STEPS = 2;
`else
  localparam int STEPS = 1;
`endif
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH / STEPS - 1);

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_divisor;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_rem;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_quot;
  logic [WIDTH-1:0] r_remd;
  logic             r_dz;
  logic             r_ovf;

  logic             w_dz;
  logic             w_ovf;
  logic [WIDTH-1:0] w_rem_a;
  logic             w_q_a;
  logic [WIDTH-1:0] w_rem_step;
  logic [WIDTH-1:0] w_lo_step;

  assign w_dz  = (r_divisor == '0);
  assign w_ovf = !w_dz && (r_hi >= r_divisor);

  // r_lo shifts dividend bits out the top while quotient bits enter at the bottom.
  divider_step #(.WIDTH(WIDTH)) u_step0 (
    .rem_in (r_rem),
    .bit_in (r_lo[WIDTH-1]),
    .divisor(r_divisor),
    .rem_out(w_rem_a),
    .qbit   (w_q_a)
  );

`ifdef DIVIDER_128_BY_64_RADIX4_EN
  logic [WIDTH-1:0] w_rem_b;
  logic             w_q_b;

  divider_step #(.WIDTH(WIDTH)) u_step1 (
    .rem_in (w_rem_a),
    .bit_in (r_lo[WIDTH-2]),
    .divisor(r_divisor),
    .rem_out(w_rem_b),
    .qbit   (w_q_b)
  );

  assign w_rem_step = w_rem_b;
  assign w_lo_step  = {r_lo[WIDTH-3:0], w_q_a, w_q_b};
`else
  assign w_rem_step = w_rem_a;
  assign w_lo_step  = {r_lo[WIDTH-2:0], w_q_a};
`endif

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (in_valid) w_next = S_CHECK;
      S_CHECK: w_next = (w_dz || w_ovf) ? S_DONE : S_DIV;
      S_DIV:   if (r_cnt == LAST_CNT) w_next = S_DONE;
      S_DONE:  if (r_out_valid && out_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt       <= '0;
      r_divisor   <= '0;
      r_hi        <= '0;
      r_lo        <= '0;
      r_rem       <= '0;
      r_out_valid <= 1'b0;
      r_quot      <= '0;
      r_remd      <= '0;
      r_dz        <= 1'b0;
      r_ovf       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_hi      <= dividend[2*WIDTH-1:WIDTH];
            r_lo      <= dividend[WIDTH-1:0];
            r_divisor <= divisor;
          end
        end
        S_CHECK: begin
          r_cnt <= '0;
          r_dz  <= w_dz;
          r_ovf <= w_ovf;
          if (w_dz || w_ovf) begin
            r_quot <= ERR_QUOTIENT[WIDTH-1:0];
            r_remd <= r_lo;
          end else begin
            r_rem <= r_hi;
          end
        end
        S_DIV: begin
          r_rem <= w_rem_step;
          r_lo  <= w_lo_step;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == LAST_CNT) begin
            r_quot <= w_lo_step;
            r_remd <= w_rem_step;
          end
        end
        S_DONE: begin
          // Valid comes up one cycle after entering DONE and drops on the handshake.
          if (!r_out_valid)   r_out_valid <= 1'b1;
          else if (out_ready) r_out_valid <= 1'b0;
        end
        default: r_out_valid <= 1'b0;
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = r_out_valid;
  assign quotient  = r_quot;
  assign remainder = r_remd;
  assign div_zero  = r_dz;
  assign overflow  = r_ovf;

endmodule

// File: tb/tb_divider_128_by_64.sv
// tb/tb_divider_128_by_64.sv - directed and random bench for divider_128_by_64 against an arithmetic model
module tb_divider_128_by_64;

`ifdef DIVIDER_128_BY_64_RADIX4_EN
  localparam int LAT_NORM = 34;
`else
  localparam int LAT_NORM = 66;
`endif
  localparam int LAT_ERR = 2;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] dividend = '0;
  logic [63:0]  divisor = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [63:0]  quotient;
  logic [63:0]  remainder;
  logic         div_zero;
  logic         overflow;

  int n_cmp = 0;
  int n_bad = 0;

  logic         exp_armed = 1'b0;
  logic [63:0]  exp_q, exp_r;
  logic         exp_dz, exp_ov;

  divider_128_by_64 dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .dividend (dividend),
    .divisor  (divisor),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .quotient (quotient),
    .remainder(remainder),
    .div_zero (div_zero),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference: plain 128-bit arithmetic plus the error-case rules.
  task automatic model(input logic [127:0] a, input logic [63:0] b,
                       output logic [63:0] q, output logic [63:0] r,
                       output logic dz, output logic ov);
    logic [127:0] q128, r128;
    dz = 1'b0;
    ov = 1'b0;
    if (b == 64'd0) begin
      dz = 1'b1;
      q  = '1;
      r  = a[63:0];
    end else if (a[127:64] >= b) begin
      ov = 1'b1;
      q  = '1;
      r  = a[63:0];
    end else begin
      q128 = a / {64'd0, b};
      r128 = a % {64'd0, b};
      q    = q128[63:0];
      r    = r128[63:0];
    end
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (!exp_armed) begin
        chk("spurious out_valid", 128'(out_valid), 128'(0));
      end else begin
        chk("quotient", 128'(quotient), 128'(exp_q));
        chk("remainder", 128'(remainder), 128'(exp_r));
        chk("div_zero", 128'(div_zero), 128'(exp_dz));
        chk("overflow", 128'(overflow), 128'(exp_ov));
        chk("in_ready while valid", 128'(in_ready), 128'(0));
      end
    end
  end

  task automatic run_op(input logic [127:0] a, input logic [63:0] b,
                        input int lat, input int hold, input string nm);
    int cyc;
    @(negedge clk);
    chk({nm, " idle in_ready"}, 128'(in_ready), 128'(1));
    model(a, b, exp_q, exp_r, exp_dz, exp_ov);
    exp_armed = 1'b1;
    in_valid  = 1'b1;
    dividend  = a;
    divisor   = b;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    dividend = ~a;
    divisor  = ~b;
    cyc = 0;
    while (!out_valid && cyc < 200) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk({nm, " latency"}, 128'(cyc), 128'(lat));
    repeat (hold) @(posedge clk);
    #1;
    chk({nm, " busy in_ready"}, 128'(in_ready), 128'(0));
    chk({nm, " held valid"}, 128'(out_valid), 128'(1));
    if (out_valid && !exp_dz && !exp_ov)
      chk({nm, " q*d+r"}, 128'(quotient) * 128'(b) + 128'(remainder), a);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    exp_armed = 1'b0;
    chk({nm, " valid drop"}, 128'(out_valid), 128'(0));
    chk({nm, " ready back"}, 128'(in_ready), 128'(1));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0]  q, r, b;
    logic         dz, ov;
    logic [127:0] a;

    model(128'd100, 64'd7, q, r, dz, ov);
    chk("model 100/7 q", 128'(q), 128'd14);
    chk("model 100/7 r", 128'(r), 128'd2);
    model({64'd5, 64'd9}, 64'd5, q, r, dz, ov);
    chk("model ovf flag", 128'(ov), 128'd1);
    chk("model ovf q", 128'(q), 128'hFFFF_FFFF_FFFF_FFFF);
    model({64'd3, 64'd0}, 64'd0, q, r, dz, ov);
    chk("model dz flag", 128'(dz), 128'd1);

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("reset in_ready", 128'(in_ready), 128'd1);
    chk("reset out_valid", 128'(out_valid), 128'd0);
    chk("reset quotient", 128'(quotient), 128'd0);
    chk("reset remainder", 128'(remainder), 128'd0);
    chk("reset flags", 128'({div_zero, overflow}), 128'd0);

    run_op(128'd100, 64'd7, LAT_NORM, 0, "100/7");
    chk("100/7 lit q", 128'(exp_q), 128'd14);
    run_op({64'd0, 64'hFFFF_FFFF_FFFF_FFFF}, 64'd1, LAT_NORM, 0, "ones/1");
    run_op({64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321}, 64'd0, LAT_ERR, 3, "div0");
    run_op({64'd5, 64'd77}, 64'd5, LAT_ERR, 20, "ovf");
    run_op({64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFF}, 64'hFFFF_FFFF_FFFF_FFFF,
           LAT_NORM, 20, "max");
    run_op({64'd4, 64'd0}, 64'd5, LAT_NORM, 0, "hi<d");

    @(negedge clk);
    in_valid = 1'b1;
    dividend = {64'd1, 64'hAAAA_5555_AAAA_5555};
    divisor  = 64'd3;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (31) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("abort in_ready", 128'(in_ready), 128'd1);
    chk("abort out_valid", 128'(out_valid), 128'd0);
    chk("abort quotient", 128'(quotient), 128'd0);
    rst = 1'b0;
    run_op(128'd100, 64'd10, LAT_NORM, 0, "100/10");
    chk("100/10 lit r", 128'(exp_r), 128'd0);

    for (int i = 0; i < 40; i++) begin
      b = {$urandom, $urandom};
      if (i % 4 == 0) b = 64'($urandom_range(1, 1000));
      if (b == 64'd0) b = 64'd1;
      a = {{$urandom, $urandom} % b, $urandom, $urandom};
      run_op(a, b, LAT_NORM, i % 3, "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
